// File: rtl/deskew_ctrl_regs.sv
// Control/status register bank for N_CH deskew engines: start pulses, busy tracking,
// sticky W1C done/err flags and a level interrupt gated by a per-channel enable.
module deskew_ctrl_regs #(
    parameter int N_CH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reg_wr_i,
    input  logic            reg_rd_i,
    input  logic [2:0]      reg_addr_i,
    input  logic [N_CH-1:0] reg_wdata_i,
    output logic [N_CH-1:0] reg_rdata_o,
    output logic [N_CH-1:0] start_o,
    input  logic [N_CH-1:0] ready_i,
    output logic            irq_o
);

    typedef enum logic [1:0] {IDLE, START, WAIT_LO, RUN} ch_state_t;

    localparam logic [2:0] ADDR_CMD    = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_DONE   = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd3;
    localparam logic [2:0] ADDR_ERR    = 3'd4;

    ch_state_t state_q [N_CH];
    ch_state_t state_d [N_CH];

    logic            cmd_wr;
    logic [N_CH-1:0] accept;
    logic [N_CH-1:0] reject;
    logic [N_CH-1:0] done_set;
    logic [N_CH-1:0] busy;
    logic [N_CH-1:0] done_q;
    logic [N_CH-1:0] err_q;
    logic [N_CH-1:0] irq_en_q;
    logic [N_CH-1:0] done_clr;
    logic [N_CH-1:0] err_clr;
    logic [N_CH-1:0] rd_mux;

    assign cmd_wr = reg_wr_i && (reg_addr_i == ADDR_CMD);

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_CH; k++) begin
            if (reset) state_q[k] <= IDLE;
            else       state_q[k] <= state_d[k];
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                IDLE:    if (accept[k])    state_d[k] = START;
                START:                     state_d[k] = WAIT_LO;
                WAIT_LO: if (!ready_i[k])  state_d[k] = RUN;
                RUN:     if (ready_i[k])   state_d[k] = IDLE;
                default:                   state_d[k] = IDLE;
            endcase
        end
    end

    // A start request only lands on an idle channel whose engine reports ready;
    // any other requested bit is flagged as an error and leaves the FSM alone.
    always_comb begin
        start_o  = '0;
        busy     = '0;
        done_set = '0;
        accept   = '0;
        reject   = '0;
        for (int k = 0; k < N_CH; k++) begin
            start_o[k]  = (state_q[k] == START);
            busy[k]     = (state_q[k] != IDLE);
            done_set[k] = (state_q[k] == RUN) && ready_i[k];
            accept[k]   = cmd_wr && reg_wdata_i[k] && (state_q[k] == IDLE) && ready_i[k];
            reject[k]   = cmd_wr && reg_wdata_i[k] && !accept[k];
        end
    end

    assign done_clr = (reg_wr_i && (reg_addr_i == ADDR_DONE)) ? reg_wdata_i : '0;
    assign err_clr  = (reg_wr_i && (reg_addr_i == ADDR_ERR))  ? reg_wdata_i : '0;

    // Sticky flags: a set arriving in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q   <= '0;
            err_q    <= '0;
            irq_en_q <= '0;
        end else begin
            done_q <= (done_q & ~done_clr) | done_set;
            err_q  <= (err_q & ~err_clr) | reject;
            if (reg_wr_i && (reg_addr_i == ADDR_IRQ_EN))
                irq_en_q <= reg_wdata_i;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr_i)
            ADDR_STATUS: rd_mux = busy;
            ADDR_DONE:   rd_mux = done_q;
            ADDR_IRQ_EN: rd_mux = irq_en_q;
            ADDR_ERR:    rd_mux = err_q;
            default:     rd_mux = '0;
        endcase
    end

    // Read data is captured from current register values, so a simultaneous
    // write is only visible to a later read.
    always_ff @(posedge clk) begin
        if (reset)         reg_rdata_o <= '0;
        else if (reg_rd_i) reg_rdata_o <= rd_mux;
    end

    assign irq_o = |(done_q & irq_en_q);

endmodule

// File: tb/tb_deskew_ctrl_regs.sv
// Bench for deskew_ctrl_regs: directed vector table, hand-written reset sequence,
// then random traffic compared against a flag-based behavioural model.
module tb_deskew_ctrl_regs;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reg_wr = 1'b0;
    logic       reg_rd = 1'b0;
    logic [2:0] reg_addr = 3'd0;
    logic [3:0] reg_wdata = 4'h0;
    logic [3:0] reg_rdata;
    logic [3:0] start;
    logic [3:0] ready = 4'hF;
    logic       irq;

    int tests_run = 0;
    int tests_failed = 0;

    deskew_ctrl_regs #(.N_CH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .reg_wr_i   (reg_wr),
        .reg_rd_i   (reg_rd),
        .reg_addr_i (reg_addr),
        .reg_wdata_i(reg_wdata),
        .reg_rdata_o(reg_rdata),
        .start_o    (start),
        .ready_i    (ready),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    // Model: each channel is busy from an accepted command until the engine has
    // gone low and come back high; the first busy cycle is the start pulse.
    logic [3:0] m_busy = '0, m_pulse = '0, m_low_seen = '0;
    logic [3:0] m_done = '0, m_err = '0, m_en = '0, m_rdata = '0;

    task automatic modelStep();
        logic [3:0] nb, np, nl, dset, eset;
        nb = m_busy; np = m_pulse; nl = m_low_seen; dset = '0; eset = '0;
        if (reset) begin
            m_busy = '0; m_pulse = '0; m_low_seen = '0;
            m_done = '0; m_err = '0; m_en = '0; m_rdata = '0;
            return;
        end
        if (reg_rd) begin
            case (reg_addr)
                3'd1:    m_rdata = m_busy;
                3'd2:    m_rdata = m_done;
                3'd3:    m_rdata = m_en;
                3'd4:    m_rdata = m_err;
                default: m_rdata = '0;
            endcase
        end
        for (int k = 0; k < 4; k++) begin
            if (m_pulse[k]) np[k] = 1'b0;
            else if (m_busy[k] && !m_low_seen[k] && !ready[k]) nl[k] = 1'b1;
            else if (m_busy[k] && m_low_seen[k] && ready[k]) begin
                nb[k] = 1'b0; nl[k] = 1'b0; dset[k] = 1'b1;
            end
            if (reg_wr && reg_addr == 3'd0 && reg_wdata[k]) begin
                if (!m_busy[k] && ready[k]) begin nb[k] = 1'b1; np[k] = 1'b1; end
                else eset[k] = 1'b1;
            end
        end
        if (reg_wr && reg_addr == 3'd2) m_done = m_done & ~reg_wdata;
        if (reg_wr && reg_addr == 3'd4) m_err = m_err & ~reg_wdata;
        if (reg_wr && reg_addr == 3'd3) m_en = reg_wdata;
        m_done = m_done | dset;
        m_err = m_err | eset;
        m_busy = nb; m_pulse = np; m_low_seen = nl;
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] addr,
                                 input logic [3:0] wdata, input logic [3:0] rdy, input logic rst);
        reg_wr = wr; reg_rd = rd; reg_addr = addr; reg_wdata = wdata; ready = rdy; reset = rst;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_start,
                               input logic [3:0] exp_rdata, input logic exp_irq);
        tests_run++;
        if (start !== exp_start || reg_rdata !== exp_rdata || irq !== exp_irq) begin
            tests_failed++;
            $display("[TB] FAIL %s: got start=%h rdata=%h irq=%b, expected start=%h rdata=%h irq=%b",
                     name, start, reg_rdata, irq, exp_start, exp_rdata, exp_irq);
        end
    endtask

    typedef struct {
        logic       wr;
        logic       rd;
        logic [2:0] addr;
        logic [3:0] wdata;
        logic [3:0] ready;
        int         rep;
        logic [3:0] exp_start;
        logic [3:0] exp_rdata;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic rd, logic [2:0] addr, logic [3:0] wdata,
                                logic [3:0] rdy, int rep, logic [3:0] es, logic [3:0] er, logic ei);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.ready = rdy;
        v.rep = rep; v.exp_start = es; v.exp_rdata = er; v.exp_irq = ei;
        return v;
    endfunction

    initial begin
        //                wr  rd  addr  wdata  ready rep start rdata irq
        vecs.push_back(mk(0, 1, 3'd0, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 3'd2, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 3'd3, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 3'd4, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 3'd7, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 0, 3'd0, 4'h5, 4'hF, 1, 4'h5, 4'h0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 4'h0, 4'hF, 1, 4'h0, 4'h5, 0));
        vecs.push_back(mk(0, 0, 3'd0, 4'h0, 4'hA, 10, 4'h0, 4'h5, 0));
        vecs.push_back(mk(0, 0, 3'd0, 4'h0, 4'hF, 1, 4'h0, 4'h5, 0));
        vecs.push_back(mk(0, 1, 3'd2, 4'h0, 4'hF, 1, 4'h0, 4'h5, 0));
        vecs.push_back(mk(0, 1, 3'd1, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 0, 3'd3, 4'h1, 4'hF, 1, 4'h0, 4'h0, 1));
        vecs.push_back(mk(0, 1, 3'd3, 4'h0, 4'hF, 1, 4'h0, 4'h1, 1));
        vecs.push_back(mk(1, 0, 3'd2, 4'h1, 4'hF, 1, 4'h0, 4'h1, 0));
        vecs.push_back(mk(0, 1, 3'd2, 4'h0, 4'hF, 1, 4'h0, 4'h4, 0));
        vecs.push_back(mk(1, 0, 3'd0, 4'h2, 4'hF, 1, 4'h2, 4'h4, 0));
        vecs.push_back(mk(0, 0, 3'd0, 4'h0, 4'hD, 1, 4'h0, 4'h4, 0));
        vecs.push_back(mk(1, 0, 3'd0, 4'h2, 4'hD, 1, 4'h0, 4'h4, 0));
        vecs.push_back(mk(0, 1, 3'd4, 4'h0, 4'hD, 1, 4'h0, 4'h2, 0));
        vecs.push_back(mk(1, 0, 3'd4, 4'h2, 4'hD, 1, 4'h0, 4'h2, 0));
        vecs.push_back(mk(0, 1, 3'd4, 4'h0, 4'hD, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 3'd1, 4'h0, 4'hD, 1, 4'h0, 4'h2, 0));
        vecs.push_back(mk(0, 0, 3'd0, 4'h0, 4'hF, 1, 4'h0, 4'h2, 0));
        vecs.push_back(mk(0, 1, 3'd2, 4'h0, 4'hF, 1, 4'h0, 4'h6, 0));
        vecs.push_back(mk(1, 0, 3'd0, 4'h8, 4'hF, 1, 4'h8, 4'h6, 0));
        vecs.push_back(mk(0, 0, 3'd0, 4'h0, 4'h7, 2, 4'h0, 4'h6, 0));
        vecs.push_back(mk(1, 0, 3'd2, 4'h8, 4'hF, 1, 4'h0, 4'h6, 0));
        vecs.push_back(mk(0, 1, 3'd2, 4'h0, 4'hF, 1, 4'h0, 4'hE, 0));
        vecs.push_back(mk(1, 1, 3'd3, 4'hF, 4'hF, 1, 4'h0, 4'h1, 1));
        vecs.push_back(mk(0, 1, 3'd3, 4'h0, 4'hF, 1, 4'h0, 4'hF, 1));
        vecs.push_back(mk(1, 0, 3'd2, 4'hF, 4'hF, 1, 4'h0, 4'hF, 0));
        vecs.push_back(mk(1, 0, 3'd5, 4'hF, 4'hF, 1, 4'h0, 4'hF, 0));
        vecs.push_back(mk(0, 1, 3'd5, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 1, 3'd1, 4'hF, 4'hF, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 0, 3'd0, 4'h1, 4'hE, 1, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 3'd4, 4'h0, 4'hF, 1, 4'h0, 4'h1, 0));
        vecs.push_back(mk(1, 0, 3'd4, 4'hF, 4'hF, 1, 4'h0, 4'h1, 0));
        vecs.push_back(mk(0, 1, 3'd4, 4'h0, 4'hF, 1, 4'h0, 4'h0, 0));

        applyStimulus(0, 0, 3'd0, 4'h0, 4'hF, 1);
        applyStimulus(0, 0, 3'd0, 4'h0, 4'hF, 1);
        checkOutput("reset", 4'h0, 4'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].rep; r++)
                applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].ready, 0);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_start, vecs[i].exp_rdata, vecs[i].exp_irq);
        end

        // Reset while channel 2 is running, then let its engine finish.
        applyStimulus(1, 1, 3'd0, 4'h4, 4'hF, 0);
        checkOutput("mid_start", 4'h4, 4'h0, 1'b0);
        applyStimulus(0, 1, 3'd1, 4'h0, 4'hB, 0);
        checkOutput("mid_wait", 4'h0, 4'h4, 1'b0);
        applyStimulus(0, 1, 3'd1, 4'h0, 4'hB, 0);
        checkOutput("mid_run", 4'h0, 4'h4, 1'b0);
        applyStimulus(0, 0, 3'd0, 4'h0, 4'hB, 1);
        checkOutput("mid_reset", 4'h0, 4'h0, 1'b0);
        applyStimulus(0, 1, 3'd1, 4'h0, 4'hB, 0);
        checkOutput("mid_status", 4'h0, 4'h0, 1'b0);
        applyStimulus(0, 1, 3'd2, 4'h0, 4'hF, 0);
        checkOutput("mid_done", 4'h0, 4'h0, 1'b0);
        applyStimulus(0, 1, 3'd2, 4'h0, 4'hF, 0);
        checkOutput("mid_no_done", 4'h0, 4'h0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] rdy;
            rdy = ready;
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 4) == 0) rdy[k] = ~rdy[k];
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                          3'($urandom_range(0, 7)), 4'($urandom), rdy,
                          ($urandom_range(0, 199) == 0));
            checkOutput($sformatf("rand%0d", i), m_pulse, m_rdata, |(m_done & m_en));
        end

        reg_wr = 1'b0; reg_rd = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/deskew_ctrl_regs.md
# deskew_ctrl_regs

Parametrised control/status register bank between the AXI-Lite slave and N_CH deskew engines. Turns software command writes into one-cycle per-channel start pulses and tracks each engine's busy/done state from its ready line. Provides sticky done and error flags (write-1-to-clear) and a level interrupt with per-channel enable.

## Interface
Parameters:
- N_CH, 4, number of deskew channels (1..32); also the register data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- reg_wr_i  in  1  write strobe from the AXI slave, one cycle per write.
- reg_rd_i  in  1  read strobe from the AXI slave, one cycle per read.
- reg_addr_i  in  3  register index: 0 CMD, 1 STATUS, 2 DONE, 3 IRQ_EN, 4 ERR; 5..7 reserved.
- reg_wdata_i  in  N_CH  write data, bit k = channel k.
- reg_rdata_o  out  N_CH  registered read data.
- start_o  out  N_CH  per-channel start pulse to the engines.
- ready_i  in  N_CH  per-channel engine ready (1 = idle).
- irq_o  out  1  level interrupt.

## Operation
- Per-channel FSM, states IDLE, START, WAIT_LO, RUN:
  - IDLE -> START: CMD write with wdata[k]=1 while ready_i[k]=1. Otherwise stay.
  - START: start_o[k]=1 for exactly this cycle. Always goes to WAIT_LO next.
  - WAIT_LO -> RUN: ready_i[k]=0.
  - RUN -> IDLE: ready_i[k]=1. On this transition done[k] is set.
- busy[k] = 1 in any state other than IDLE.
- CMD write with wdata[k]=1 is rejected when the channel is busy, or when it is IDLE with ready_i[k]=0:
  - err[k] is set.
  - No pulse is issued and the FSM state is unchanged.
- Bits with wdata[k]=0 have no effect. Several channels can be started by one write.
- Register behaviour:
  - CMD (0): write-only; reads return 0.
  - STATUS (1): read-only busy vector; writes ignored.
  - DONE (2): sticky; written 1 clears the bit, 0 has no effect.
  - IRQ_EN (3): read/write.
  - ERR (4): sticky; written 1 clears the bit.
  - Reserved addresses: reads return 0, writes ignored.
- irq_o = OR over k of (done[k] & irq_en[k]). Driven combinationally from registered state only.
- Simultaneous events:
  - done set and W1C clear on the same bit in the same cycle: set wins.
  - The same rule applies to err.
  - reg_wr_i and reg_rd_i both high: both are performed. Read data reflects the pre-write register values.
- Reset values, when reset=1 at a clock edge:
  - All FSMs go to IDLE.
  - start_o, busy, done, err, irq_en, reg_rdata_o all = 0, hence irq_o = 0.
  - Reset mid-run abandons the transaction. No done is reported for it.

## Timing
- CMD write sampled at edge t: start_o[k] is high from t to t+1 (one cycle). STATUS busy[k]=1 from t.
- Back-to-back CMD writes to a channel in START or WAIT_LO: the second write is rejected and sets err.
- ready_i[k] rise sampled at edge t while in RUN: done[k]=1 and busy[k]=0 after t. irq_o rises after t if enabled.
- Read sampled at edge t: reg_rdata_o is valid after t. It holds its value until the next read.
- An IRQ_EN write takes effect on irq_o in the cycle after the write edge.
- An engine that keeps ready_i high forever leaves the channel in WAIT_LO. Software recovers via reset. No timeout.

## Test plan
- N_CH=4, reset, then read every address -> all 0; irq_o=0; start_o=0.
- ready_i=4'hF, write CMD=4'b0101 -> start_o=4'b0101 for exactly one cycle; STATUS reads 4'b0101. Then drop ready_i[0] and ready_i[2] for 10 cycles and raise them -> DONE=4'b0101, STATUS=0.
- IRQ_EN=4'b0001 with DONE=4'b0101 -> irq_o=1. Write DONE=4'b0001 -> irq_o=0 next cycle; DONE reads 4'b0100.
- Channel 1 in RUN, write CMD=4'b0010 -> no start_o pulse; ERR=4'b0010. Write ERR=4'b0010 -> ERR=0.
- Same-cycle case: ready_i[3] rises in RUN in the same cycle as a DONE write of 4'b1000 -> DONE[3] reads 1.
- Reset asserted while channel 2 is in RUN -> STATUS=0, DONE=0. A later ready_i[2] rise sets no done.
